// File: rtl/aes_decipher_engine.sv
// AES inverse cipher round engine (AES-128/192/256) with a lane-serial inverse
// S-box stage of SBOX_WORDS 32-bit words per cycle; round keys come from an external key memory.
module aes_decipher_engine #(
  parameter int SBOX_WORDS = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         abort,
  input  logic [1:0]   keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready,
  output logic         valid,
  output logic         err
);

  localparam int S = 4 / SBOX_WORDS;
  localparam logic [1:0] CTR_LAST = 2'(S - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] INIT = 2'd1;
  localparam logic [1:0] SBOX = 2'd2;
  localparam logic [1:0] MAIN = 2'd3;

  generate
    if (!(SBOX_WORDS == 1 || SBOX_WORDS == 2 || SBOX_WORDS == 4)) begin : g_bad_param
      $error("aes_decipher_engine: SBOX_WORDS must be 1, 2 or 4");
    end
  endgenerate

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Inverse affine map, then GF(2^8) inverse as x^254 (maps 0 to 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b, sq, acc;
    b   = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    sq  = b;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  // Row r of column c comes from column (c - r) mod 4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-32*c-8*r -: 8] = s[127-32*((c-r+4)%4)-8*r -: 8];
    return o;
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    return 4'd10 + {1'b0, kl, 1'b0};
  endfunction

  logic [1:0]   state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [1:0]   ctr_q, ctr_d;
  logic [1:0]   keylen_q, keylen_d;
  logic [127:0] blk_q, blk_d;
  logic         blk_en;
  logic         ready_q, ready_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;

  logic [3:0][31:0]            blk_w, sub_w;
  logic [SBOX_WORDS-1:0][1:0]  lane_idx;
  logic [SBOX_WORDS-1:0][31:0] lane_in, lane_out;

  // Word 0 sits in the most significant 32 bits, i.e. packed index 3.
  assign blk_w = blk_q;

  generate
    for (genvar l = 0; l < SBOX_WORDS; l++) begin : g_lane
      assign lane_idx[l] = 2'(int'(ctr_q) * SBOX_WORDS + l);
      assign lane_in[l]  = blk_w[2'd3 - lane_idx[l]];
      for (genvar b = 0; b < 4; b++) begin : g_byte
        assign lane_out[l][8*b +: 8] = inv_sbox(lane_in[l][8*b +: 8]);
      end
    end
  endgenerate

  always_comb begin
    sub_w = blk_w;
    for (int l = 0; l < SBOX_WORDS; l++) sub_w[2'd3 - lane_idx[l]] = lane_out[l];
  end

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    ctr_d    = ctr_q;
    keylen_d = keylen_q;
    blk_d    = blk_q;
    ready_d  = ready_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (next) begin
          if (keylen == 2'd3) begin
            err_d = 1'b1;
          end else begin
            keylen_d = keylen;
            round_d  = nr_of(keylen);
            ready_d  = 1'b0;
            state_d  = INIT;
          end
        end
      end
      INIT: begin
        blk_d   = block ^ round_key;
        round_d = nr_of(keylen_q) - 4'd1;
        ctr_d   = '0;
        state_d = SBOX;
      end
      SBOX: begin
        blk_d = sub_w;
        if (ctr_q == CTR_LAST) begin
          ctr_d   = '0;
          state_d = MAIN;
        end else begin
          ctr_d = ctr_q + 2'd1;
        end
      end
      MAIN: begin
        if (round_q != 4'd0) begin
          blk_d   = inv_mix(inv_shift_rows(blk_q) ^ round_key);
          round_d = round_q - 4'd1;
          state_d = SBOX;
        end else begin
          blk_d   = inv_shift_rows(blk_q) ^ round_key;
          ready_d = 1'b1;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over every busy-state update, including the final round.
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      ready_d = 1'b1;
      round_d = '0;
      ctr_d   = '0;
      valid_d = 1'b0;
      blk_d   = blk_q;
    end
  end

  assign blk_en = (state_q != IDLE) && !abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      round_q  <= '0;
      ctr_q    <= '0;
      keylen_q <= '0;
      blk_q    <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      ctr_q    <= ctr_d;
      keylen_q <= keylen_d;
      if (blk_en) blk_q <= blk_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign round     = round_q;
  assign new_block = blk_q;
  assign ready     = ready_q;
  assign valid     = valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_aes_decipher_engine.sv
// Bench for aes_decipher_engine: three instances (1, 2, 4 S-box lanes) fed by a
// key-expansion model; FIPS-197 appendix C vectors, abort, illegal keylen, busy next, reset.
module tb_aes_decipher_engine;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         reset_n, next, abort;
  logic [1:0]   keylen;
  logic [127:0] block;
  logic [3:0]   rnd [3];
  logic [127:0] rk  [3];
  logic [127:0] nb  [3];
  logic         rdy [3];
  logic         vld [3];
  logic         er  [3];
  logic [127:0] rk_tab [0:15];

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_q [$];
  int           obs_vcnt, obs_vn, obs_rn;
  logic [127:0] obs_nb;
  logic [3:0]   rseq [$];

  always #5 clk = ~clk;

  assign rk[0] = rk_tab[rnd[0]];
  assign rk[1] = rk_tab[rnd[1]];
  assign rk[2] = rk_tab[rnd[2]];

  aes_decipher_engine #(.SBOX_WORDS(1)) u_w1 (
    .clk(clk), .reset_n(reset_n), .next(next), .abort(abort), .keylen(keylen),
    .round(rnd[0]), .round_key(rk[0]), .block(block), .new_block(nb[0]),
    .ready(rdy[0]), .valid(vld[0]), .err(er[0]));
  aes_decipher_engine #(.SBOX_WORDS(2)) u_w2 (
    .clk(clk), .reset_n(reset_n), .next(next), .abort(abort), .keylen(keylen),
    .round(rnd[1]), .round_key(rk[1]), .block(block), .new_block(nb[1]),
    .ready(rdy[1]), .valid(vld[1]), .err(er[1]));
  aes_decipher_engine #(.SBOX_WORDS(4)) u_w4 (
    .clk(clk), .reset_n(reset_n), .next(next), .abort(abort), .keylen(keylen),
    .round(rnd[2]), .round_key(rk[2]), .block(block), .new_block(nb[2]),
    .ready(rdy[2]), .valid(vld[2]), .err(er[2]));

  // Key-memory model: forward S-box by brute-force GF inverse plus affine map.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] inv, s;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gf_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {fwd_sbox(w[31:24]), fwd_sbox(w[23:16]), fwd_sbox(w[15:8]), fwd_sbox(w[7:0])};
  endfunction

  task automatic expand_key(input int kl);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    nk = 4 + 2 * kl;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    rc = 8'h01;
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk_tab[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  task automatic wait_idle(input int d);
    for (int i = 0; i < 200 && !rdy[d]; i++) @(negedge clk);
    checks++;
    if (rdy[d] !== 1'b1) begin
      errors++;
      $display("FAIL idle_timeout dut%0d ready=%b required 1", d, rdy[d]);
    end
  endtask

  // Returns just after the edge that samples next (edge 0).
  task automatic drive_next(input int kl, input logic [127:0] ct, input logic [127:0] pt);
    expand_key(kl);
    @(negedge clk);
    keylen = 2'(kl);
    block  = ct;
    next   = 1'b1;
    exp_q.push_back(pt);
    @(posedge clk);
    #1 next = 1'b0;
  endtask

  task automatic observe(input int d, input int maxn, input bit poke);
    obs_vcnt = 0; obs_vn = -1; obs_rn = -1; obs_nb = '0;
    rseq.delete();
    rseq.push_back(rnd[d]);
    for (int n = 1; n <= maxn; n++) begin
      @(posedge clk);
      #1;
      if (vld[d]) begin
        obs_vcnt++;
        if (obs_vn < 0) begin obs_vn = n; obs_nb = nb[d]; end
      end
      if (rdy[d] && obs_rn < 0) obs_rn = n;
      if (rnd[d] != rseq[$]) rseq.push_back(rnd[d]);
      next = poke && (n % 5 == 2) && (n < 40);
      if (poke) begin
        keylen = 2'(n % 4);
        block  = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    end
    next = 1'b0;
  endtask

  task automatic check_run(input string tag, input int lat);
    logic [127:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : {128{1'bx}};
    checks++;
    if (obs_nb !== e) begin errors++; $display("FAIL %s_pt got %h required %h", tag, obs_nb, e); end
    checks++;
    if (obs_vcnt != 1) begin errors++; $display("FAIL %s_valid_count got %0d required 1", tag, obs_vcnt); end
    checks++;
    if (obs_rn != lat) begin errors++; $display("FAIL %s_latency got %0d required %0d", tag, obs_rn, lat); end
    checks++;
    if (obs_vn != lat) begin errors++; $display("FAIL %s_valid_edge got %0d required %0d", tag, obs_vn, lat); end
  endtask

  task automatic test_reset();
    reset_n = 1'b1; next = 1'b0; abort = 1'b0; keylen = 2'd0; block = '0;
    expand_key(0);
    #2 reset_n = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (rdy[d] !== 1'b1) begin errors++; $display("FAIL reset_ready dut%0d got %b required 1", d, rdy[d]); end
      checks++;
      if (vld[d] !== 1'b0 || er[d] !== 1'b0) begin
        errors++; $display("FAIL reset_pulses dut%0d valid=%b err=%b required 0 0", d, vld[d], er[d]);
      end
      checks++;
      if (rnd[d] !== 4'd0) begin errors++; $display("FAIL reset_round dut%0d got %0d required 0", d, rnd[d]); end
      checks++;
      if (nb[d] !== 128'h0) begin errors++; $display("FAIL reset_block dut%0d got %h required 0", d, nb[d]); end
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_c1();
    wait_idle(0);
    drive_next(0, CT1, PT);
    observe(0, 60, 1'b0);
    check_run("c1", 51);
  endtask

  task automatic test_c2();
    bit ok;
    wait_idle(1);
    drive_next(1, CT2, PT);
    observe(1, 50, 1'b0);
    check_run("c2", 37);
    ok = (rseq.size() == 13);
    for (int i = 0; i < 13 && i < rseq.size(); i++)
      if (rseq[i] !== 4'(12 - i)) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL c2_round_seq got %0d entries first %0d last %0d required 12 down to 0",
               rseq.size(), rseq[0], rseq[$]);
    end
  endtask

  task automatic test_c3();
    wait_idle(2);
    drive_next(2, CT3, PT);
    observe(2, 40, 1'b0);
    check_run("c3", 29);
  endtask

  task automatic test_illegal_keylen();
    wait_idle(0);
    drive_next(0, CT1, PT);
    observe(0, 60, 1'b0);
    check_run("kl3_pre", 51);
    @(negedge clk);
    keylen = 2'd3;
    block  = CT2;
    next   = 1'b1;
    @(posedge clk);
    #1 next = 1'b0;
    checks++;
    if (er[0] !== 1'b1) begin errors++; $display("FAIL kl3_err_pulse got %b required 1", er[0]); end
    checks++;
    if (rdy[0] !== 1'b1) begin errors++; $display("FAIL kl3_ready got %b required 1", rdy[0]); end
    @(posedge clk);
    #1;
    checks++;
    if (er[0] !== 1'b0) begin errors++; $display("FAIL kl3_err_width got %b required 0", er[0]); end
    checks++;
    if (rdy[0] !== 1'b1 || nb[0] !== PT) begin
      errors++; $display("FAIL kl3_hold ready=%b block=%h required 1 %h", rdy[0], nb[0], PT);
    end
    drive_next(0, CT1, PT);
    observe(0, 60, 1'b0);
    check_run("kl3_post", 51);
  endtask

  task automatic test_abort();
    int vc;
    vc = 0;
    wait_idle(0);
    drive_next(0, CT1, PT);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (vld[0]) vc++;
      if (n == 19) abort = 1'b1;
    end
    abort = 1'b0;
    checks++;
    if (rdy[0] !== 1'b1 || rnd[0] !== 4'd0) begin
      errors++; $display("FAIL abort_state ready=%b round=%0d required 1 0", rdy[0], rnd[0]);
    end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    repeat (4) begin
      @(posedge clk);
      #1;
      if (vld[0]) vc++;
    end
    checks++;
    if (vc != 0) begin errors++; $display("FAIL abort_no_valid got %0d pulses required 0", vc); end
    drive_next(0, CT1, PT);
    observe(0, 60, 1'b0);
    check_run("abort_restart", 51);
  endtask

  task automatic test_busy_next();
    wait_idle(0);
    drive_next(0, CT1, PT);
    observe(0, 60, 1'b1);
    check_run("busy_next", 51);
  endtask

  task automatic test_reset_mid();
    wait_idle(0);
    drive_next(0, CT1, PT);
    repeat (30) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (rdy[d] !== 1'b1 || vld[d] !== 1'b0 || er[d] !== 1'b0 || rnd[d] !== 4'd0 || nb[d] !== 128'h0) begin
        errors++;
        $display("FAIL mid_reset dut%0d ready=%b valid=%b err=%b round=%0d block=%h required 1 0 0 0 0",
                 d, rdy[d], vld[d], er[d], rnd[d], nb[d]);
      end
    end
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    drive_next(0, CT1, PT);
    observe(0, 60, 1'b0);
    check_run("post_reset", 51);
  endtask

  initial begin
    test_reset();
    test_c1();
    test_c2();
    test_c3();
    test_illegal_keylen();
    test_abort();
    test_busy_next();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
